// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Purpose  : Round-robin arbiter sharing one valid/ready bus among NUM_REQ
//            requesters, with a watchdog that aborts stalled transactions.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_wr_en,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           req_err,
  output logic [DATA_W-1:0]            req_rdata,
  output logic                         valid,
  output logic                         wr_en,
  output logic [ADDR_W-1:0]            addr,
  output logic [DATA_W-1:0]            wdata,
  input  logic                         ready,
  input  logic [DATA_W-1:0]            rdata,
  output logic                         grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id
);

  localparam int c_id_w   = $clog2(NUM_REQ);
  localparam int c_tcnt_w = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_tcnt_w-1:0] c_tmax  = c_tcnt_w'(TIMEOUT);
  localparam logic [c_tcnt_w-1:0] c_tlast = c_tcnt_w'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_id_w-1:0]     r_rr_ptr;
  logic [c_id_w-1:0]     r_grant_id;
  logic                  r_wr_en;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [c_tcnt_w-1:0]   r_tcnt;

  logic                  w_any;
  logic [c_id_w-1:0]     w_win;
  logic [c_id_w-1:0]     w_sel;
  logic [c_id_w-1:0]     w_ptr_nxt;
  logic                  w_abort;
  logic                  w_done;

  // Scan from the round-robin pointer upward with wrap; first set bit wins.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sel = c_id_w'((int'(r_rr_ptr) + i) % NUM_REQ);
      if (!w_any && req_valid[w_sel]) begin
        w_any = 1'b1;
        w_win = w_sel;
      end
    end
  end

  assign w_ptr_nxt = (int'(r_grant_id) == NUM_REQ - 1) ? '0 : r_grant_id + 1'b1;
  assign w_abort   = (TIMEOUT != 0) && (r_tcnt == c_tlast) && !ready;
  assign w_done    = (r_state == S_BUSY) && (ready || w_abort);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any)  w_state_nxt = S_BUSY;
      S_BUSY:  if (w_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_wr_en    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_tcnt     <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_any) begin
        r_grant_id <= w_win;
        r_wr_en    <= req_wr_en[w_win];
        r_addr     <= req_addr[int'(w_win)*ADDR_W +: ADDR_W];
        r_wdata    <= req_wdata[int'(w_win)*DATA_W +: DATA_W];
        r_tcnt     <= '0;
      end
    end else begin
      // Abort advances the pointer exactly like a normal completion.
      if (w_done) begin
        r_rr_ptr <= w_ptr_nxt;
      end else if (r_tcnt != c_tmax) begin
        r_tcnt <= r_tcnt + 1'b1;
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
      assign req_ready[g] = w_done && (r_grant_id == c_id_w'(g));
      assign req_err[g]   = req_ready[g] && w_abort && !ready;
    end
  endgenerate

  assign req_rdata   = rdata;
  assign valid       = (r_state == S_BUSY);
  assign grant_valid = (r_state == S_BUSY);
  assign wr_en       = r_wr_en;
  assign addr        = r_addr;
  assign wdata       = r_wdata;
  assign grant_id    = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter
// Purpose  : Directed scoreboard bench for bus_arbiter with a small memory slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_wr_en;
  logic [31:0]  req_addr;
  logic [127:0] req_wdata;
  logic [3:0]   req_ready;
  logic [3:0]   req_err;
  logic [31:0]  req_rdata;
  logic         valid;
  logic         wr_en;
  logic [7:0]   addr;
  logic [31:0]  wdata;
  logic         ready;
  logic [31:0]  rdata;
  logic         grant_valid;
  logic [1:0]   grant_id;

  int           delay;
  bit           stuck;
  int           bcnt;
  logic [31:0]  mem [0:255];

  int           n_vec;
  int           n_fail;

  typedef struct {
    int          id;
    bit          err;
    bit          wr;
    logic [7:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  bus_arbiter #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wr_en(req_wr_en), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .req_err(req_err), .req_rdata(req_rdata),
    .valid(valid), .wr_en(wr_en), .addr(addr), .wdata(wdata),
    .ready(ready), .rdata(rdata),
    .grant_valid(grant_valid), .grant_id(grant_id)
  );

  // Slave: answers after 'delay' stalled BUSY cycles, or never when stuck.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bcnt <= 0;
    else if (valid && !ready) bcnt <= bcnt + 1;
    else bcnt <= 0;
  end
  assign ready = stuck ? 1'b0 : (bcnt >= delay);
  assign rdata = mem[addr];

  always @(posedge clk) begin
    if (valid && ready && wr_en) mem[addr] <= wdata;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && req_ready != 4'b0) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL sb_unexpected: got req_ready=%0h, expected no completion", req_ready);
        end else begin
          e = exp_q.pop_front();
          chk("sb_ready", {60'b0, req_ready}, 64'(1) << e.id);
          chk("sb_err", {60'b0, req_err}, e.err ? (64'(1) << e.id) : 64'(0));
          chk("sb_wr_en", {63'b0, wr_en}, {63'b0, e.wr});
          chk("sb_addr", {56'b0, addr}, {56'b0, e.a});
          if (e.wr) chk("sb_wdata", {32'b0, wdata}, {32'b0, e.d});
          else      chk("sb_rdata", {32'b0, req_rdata}, {32'b0, e.d});
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_done();
    for (int i = 0; i < 4; i++) if (req_ready[i]) req_valid[i] = 1'b0;
  endtask

  task automatic set_req(input int i, input bit wr, input logic [7:0] a, input logic [31:0] d);
    req_wr_en[i]        = wr;
    req_addr[i*8 +: 8]  = a;
    req_wdata[i*32 +: 32] = d;
    req_valid[i]        = 1'b1;
  endtask

  task automatic push(input int id, input bit err, input bit wr, input logic [7:0] a, input logic [31:0] d);
    exp_t e;
    e.id = id; e.err = err; e.wr = wr; e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic drain();
    int b = 0;
    while (exp_q.size() != 0 && b < 60) begin
      clear_done();
      step();
      b++;
    end
    clear_done();
    chk("drain_budget", 64'(exp_q.size()), 64'(0));
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec = 0; n_fail = 0;
    rst = 1'b1; req_valid = '0; req_wr_en = '0; req_addr = '0; req_wdata = '0;
    delay = 0; stuck = 1'b0;
    fork monitor(); join_none

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", {63'b0, valid}, 64'(0));
    chk("rst_grant_valid", {63'b0, grant_valid}, 64'(0));
    chk("rst_grant_id", {62'b0, grant_id}, 64'(0));
    chk("rst_bus", {23'b0, wr_en, addr, wdata}, 64'(0));
    chk("rst_req_ready", {56'b0, req_err, req_ready}, 64'(0));
    rst = 1'b0;

    // Single write then read-back on requester 1
    push(1, 0, 1, 8'h10, 32'hDEADBEEF);
    set_req(1, 1, 8'h10, 32'hDEADBEEF);
    chk("wr_valid_before", {63'b0, valid}, 64'(0));
    step();
    chk("wr_valid_after", {63'b0, valid}, 64'(1));
    chk("wr_grant_id", {62'b0, grant_id}, 64'(1));
    clear_done();
    step();
    chk("wr_idle", {63'b0, valid}, 64'(0));
    push(1, 0, 0, 8'h10, 32'hDEADBEEF);
    set_req(1, 0, 8'h10, 32'h0);
    step();
    chk("rd_grant_id", {62'b0, grant_id}, 64'(1));
    clear_done();
    step();

    // Requesters 0 and 2 together from reset
    do_reset();
    push(0, 0, 1, 8'h20, 32'hA0A0A0A0);
    push(2, 0, 1, 8'h22, 32'hA2A2A2A2);
    set_req(0, 1, 8'h20, 32'hA0A0A0A0);
    set_req(2, 1, 8'h22, 32'hA2A2A2A2);
    step();
    chk("sim_first", {61'b0, valid, grant_id}, 64'h4);
    clear_done();
    step();
    chk("sim_gap", {63'b0, valid}, 64'(0));
    step();
    chk("sim_second", {61'b0, valid, grant_id}, 64'h6);
    clear_done();
    step();
    chk("sim_end", {63'b0, valid}, 64'(0));

    // All four held continuously: strict rotation 0,1,2,3,0,1
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1, 8'(8'h40 + i), 32'(32'hC000 + i));
    for (int k = 0; k < 6; k++) push(k % 4, 0, 1, 8'(8'h40 + k % 4), 32'(32'hC000 + k % 4));
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_grant", {61'b0, valid, grant_id}, 64'(4 + k % 4));
      if (k == 5) req_valid = '0;
      step();
      chk("rr_gap", {63'b0, valid}, 64'(0));
    end

    // Delayed ready: bus held stable for 4 BUSY cycles
    delay = 3;
    push(3, 0, 1, 8'h33, 32'h12345678);
    set_req(3, 1, 8'h33, 32'h12345678);
    step();
    for (int c = 0; c < 4; c++) begin
      chk("dly_bus", {22'b0, valid, wr_en, addr, wdata}, {22'b0, 1'b1, 1'b1, 8'h33, 32'h12345678});
      chk("dly_ready", {60'b0, req_ready}, (c == 3) ? 64'h8 : 64'h0);
      if (c == 3) clear_done();
      step();
    end
    chk("dly_idle", {63'b0, valid}, 64'(0));

    // Watchdog: ready stuck low aborts in the 16th BUSY cycle
    delay = 0;
    stuck = 1'b1;
    push(0, 1, 1, 8'h50, 32'h55550000);
    push(1, 0, 1, 8'h51, 32'h55551111);
    set_req(0, 1, 8'h50, 32'h55550000);
    set_req(1, 1, 8'h51, 32'h55551111);
    step();
    for (int c = 0; c < 16; c++) begin
      chk("to_ready", {60'b0, req_ready}, (c == 15) ? 64'h1 : 64'h0);
      chk("to_err", {60'b0, req_err}, (c == 15) ? 64'h1 : 64'h0);
      if (c == 15) clear_done();
      step();
    end
    chk("to_idle", {63'b0, valid}, 64'(0));
    stuck = 1'b0;
    step();
    chk("to_next", {61'b0, valid, grant_id}, 64'h5);
    clear_done();
    step();

    // Reset mid-BUSY: valid drops at once, pointer returns to 0
    delay = 3;
    set_req(2, 1, 8'h62, 32'h66662222);
    step();
    chk("mid_busy", {61'b0, valid, grant_id}, 64'h6);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", {62'b0, valid, grant_valid}, 64'(0));
    chk("mid_rst_ready", {56'b0, req_err, req_ready}, 64'(0));
    req_valid = '0;
    delay = 0;
    set_req(0, 1, 8'h60, 32'h66660000);
    set_req(3, 1, 8'h63, 32'h66663333);
    push(0, 0, 1, 8'h60, 32'h66660000);
    push(3, 0, 1, 8'h63, 32'h66663333);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step();
    chk("post_rst_first", {61'b0, valid, grant_id}, 64'h4);
    clear_done();
    step();
    drain();

    chk("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
